// File: rtl/gate_selftest_seq.sv
`default_nettype none
// ============================================================================
//  Module   : gate_selftest_seq
//  Purpose  : Self-test sequencer and input arbiter for a bank of 2-input
//             gates. In idle the manual buttons drive the shared gate inputs.
//             A rising edge on start launches a run that applies all four
//             (a,b) vectors, compares every gate output against a truth-table
//             parameter and latches per-gate pass flags. LEDs show either the
//             live gate outputs or the latched result, dimmed by a PWM counter.
//  Ports    : CLK, RST_N (async, active-low)
//             start        - level; rising edge requests a run
//             man_a, man_b - manual button levels
//             gate_a/b     - shared gate inputs (out)
//             gate_y       - gate outputs, bit g = gate g (in)
//             busy, done   - registered status
//             pass         - per-gate pass flags, valid while done=1
//             led          - PWM-dimmed display outputs
//  Revision : 1.0 - initial release
// ============================================================================
module gate_selftest_seq #(
    parameter int                       N_GATES       = 5,
    parameter int                       SETTLE_CYCLES = 2,
    parameter logic [4*N_GATES-1:0]     EXPECTED      = 20'h6E837,
    parameter int                       PWM_BITS      = 8,
    parameter int                       DUTY          = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               man_a,
    input  logic               man_b,
    output logic               gate_a,
    output logic               gate_b,
    input  logic [N_GATES-1:0] gate_y,
    output logic               busy,
    output logic               done,
    output logic [N_GATES-1:0] pass,
    output logic [N_GATES-1:0] led
);

    localparam int CNT_W = (SETTLE_CYCLES + 1 <= 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [1:0]             vec;
    logic [CNT_W-1:0]       cnt;
    logic                   start_q;
    logic                   start_edge;
    logic [PWM_BITS-1:0]    pwm;
    logic                   pwm_on;
    logic [N_GATES-1:0]     mismatch;
    logic                   testing;

    assign start_edge = start & ~start_q;
    assign testing    = (state == APPLY) || (state == CHECK);

    // Compare at full integer width so DUTY values beyond the counter range
    // simply keep the LEDs lit.
    assign pwm_on = ($unsigned(32'(pwm)) < $unsigned(32'(DUTY)));

    always_comb begin
        mismatch = '0;
        for (int g = 0; g < N_GATES; g++) begin
            mismatch[g] = gate_y[g] != EXPECTED[4*g + int'(vec)];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = APPLY;
            APPLY:   if (cnt == '0) next_state = CHECK;
            CHECK:   next_state = (vec == 2'd3) ? DONE : APPLY;
            DONE:    if (start_edge) next_state = APPLY;
            default: next_state = IDLE;
        endcase
    end

    // Reset leaves start_q high so a start held through reset release is
    // not mistaken for a fresh request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            vec     <= 2'd0;
            cnt     <= '0;
            pwm     <= '0;
            start_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= '0;
        end else begin
            start_q <= start;
            pwm     <= pwm + 1'b1;
            state   <= next_state;
            busy    <= (next_state == APPLY) || (next_state == CHECK);
            done    <= (next_state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        vec  <= 2'd0;
                        cnt  <= SETTLE_INIT;
                        pass <= '1;
                    end
                end
                APPLY: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CHECK: begin
                    pass <= pass & ~mismatch;
                    if (vec != 2'd3) begin
                        vec <= vec + 2'd1;
                        cnt <= SETTLE_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gate_a = testing ? vec[1] : man_a;
        gate_b = testing ? vec[0] : man_b;
    end

    always_comb begin
        led = '0;
        case (state)
            IDLE:    led = gate_y & {N_GATES{pwm_on}};
            DONE:    led = pass & {N_GATES{pwm_on}};
            default: led = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_selftest_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_selftest_seq
//  Purpose  : Self-checking bench for gate_selftest_seq. A behavioural gate
//             bank (with optional injected faults) answers the DUT's vectors.
//             Expected results are queued when a run is launched and checked
//             by an independent monitor when done rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_selftest_seq;

    localparam int NG = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b1;
    logic          man_a = 1'b0;
    logic          man_b = 1'b0;
    logic          gate_a, gate_b, busy, done;
    logic [NG-1:0] gate_y, pass, led;
    logic          gate_a0, gate_b0, busy0, done0;
    logic [NG-1:0] gate_y0, pass0, led0;

    logic xor_stuck = 1'b0;
    logic nand_inv11 = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [NG-1:0] exp_pass_q[$];
    int            exp_len_q[$];

    always #5 clk = ~clk;

    // Gate bank model: g0 nand, g1 not(a), g2 and, g3 or, g4 xor.
    function automatic logic [NG-1:0] bank(input logic a, input logic b,
                                           input logic xs, input logic ni);
        logic [NG-1:0] y;
        y[0] = ~(a & b) ^ (ni & a & b);
        y[1] = ~a;
        y[2] = a & b;
        y[3] = a | b;
        y[4] = xs ? 1'b0 : (a ^ b);
        return y;
    endfunction

    assign gate_y  = bank(gate_a, gate_b, xor_stuck, nand_inv11);
    assign gate_y0 = bank(gate_a0, gate_b0, 1'b0, 1'b0);

    gate_selftest_seq dut (
        .CLK(clk), .RST_N(rst_n), .start(start), .man_a(man_a), .man_b(man_b),
        .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
        .busy(busy), .done(done), .pass(pass), .led(led)
    );

    gate_selftest_seq #(.DUTY(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .start(1'b0), .man_a(man_a), .man_b(man_b),
        .gate_a(gate_a0), .gate_b(gate_b0), .gate_y(gate_y0),
        .busy(busy0), .done(done0), .pass(pass0), .led(led0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the vector sequence during busy and pops the
    // scoreboard whenever a result is presented.
    int   blen = 0;
    logic busy_d = 1'b0;
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (busy && !busy_d) blen = 0;
        if (busy) begin
            check("vector_seq", {30'd0, gate_a, gate_b}, 32'(blen / 4));
            blen++;
        end
        if (done && !done_d) begin
            if (exp_pass_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("run_pass", 32'(pass), 32'(exp_pass_q.pop_front()));
                check("busy_len", 32'(blen), 32'(exp_len_q.pop_front()));
            end
        end
        busy_d = busy;
        done_d = done;
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        int on_cnt;
        // 1: start held high through reset release.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || done || pass != '0) bad++;
        end
        check("start_held_no_run", 32'(bad), 32'd0);
        @(negedge clk); start = 1'b0;

        // 2: healthy gates.
        exp_pass_q.push_back(5'b11111); exp_len_q.push_back(16);
        pulse_start();
        check("busy_first_cycle", 32'(busy), 32'd1);
        wait_done();
        check("done_held", 32'(done), 32'd1);
        man_a = 1'b0; man_b = 1'b1;
        #1 check("done_passthru", {30'd0, gate_a, gate_b}, 32'b01);

        // 3: xor stuck-at-0, nand wrong on vector 11.
        @(negedge clk);
        xor_stuck = 1'b1; nand_inv11 = 1'b1;
        exp_pass_q.push_back(5'b01110); exp_len_q.push_back(16);
        pulse_start();
        wait_done();
        xor_stuck = 1'b0; nand_inv11 = 1'b0;

        // 4: restart from DONE with an ignored re-pulse at busy cycle 5.
        exp_pass_q.push_back(5'b11111); exp_len_q.push_back(16);
        pulse_start();
        check("restart_done_low", 32'(done), 32'd0);
        check("restart_pass_ones", 32'(pass), 32'h1F);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();
        check("scoreboard_empty", 32'(exp_pass_q.size()), 32'd0);

        // 5: reset at busy cycle 7.
        pulse_start();
        repeat (6) @(negedge clk);
        check("busy_cycle7", 32'(busy), 32'd1);
        rst_n = 1'b0; man_a = 1'b1; man_b = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_passthru", {30'd0, gate_a, gate_b}, 32'b10);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        check("no_resume", 32'(bad), 32'd0);

        // 6: LED dimming in IDLE with a=1, b=0 -> y = 5'b11001.
        bad = 0; on_cnt = 0;
        repeat (512) begin
            @(negedge clk);
            if (led == 5'b11001) on_cnt++;
            else if (led != '0) bad++;
            if (led0 != '0) bad++;
        end
        check("led_on_cycles", 32'(on_cnt), 32'd16);
        check("led_bad_values", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
